period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 159 +++++++++++++++
 tb/tb_period_meter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Measures the period and high time of an asynchronous square wave in clk cycles,
// publishing each result through a valid/ready handshake with sticky overrun and timeout flags.
module period_meter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             clr,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             overrun,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, hist_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             rise, fall, sat, publish;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~hist_q;
  assign fall = ~sync2_q & hist_q;
  // Saturation wins over any edge in the same cycle so cnt never wraps.
  assign sat  = (state_q != StIdle) && (cnt_q == CntMax);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_cnt_d = hi_cnt_q;
    publish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StHigh;
          cnt_d   = CntOne;
        end
      end
      StHigh: begin
        if (sat) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (rise) begin
          // Missed fall: restart the measurement from this rise.
          cnt_d = CntOne;
        end else if (fall) begin
          hi_cnt_d = cnt_q;
          cnt_d    = cnt_q + CntOne;
          state_d  = StLow;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StLow: begin
        if (sat) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (rise) begin
          publish = 1'b1;
          cnt_d   = CntOne;
          state_d = StHigh;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
    if (clr) begin
      state_d  = StIdle;
      cnt_d    = '0;
      hi_cnt_d = '0;
      publish  = 1'b0;
    end
  end

  always_comb begin
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    if (publish) begin
      if (!valid_q || meas_ready) begin
        period_d = cnt_q;
        high_d   = hi_cnt_q;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (meas_ready) begin
      valid_d = 1'b0;
    end
    if (sat) begin
      timeout_d = 1'b1;
    end else if (rise) begin
      timeout_d = 1'b0;
    end
    if (clr) begin
      period_d  = '0;
      high_d    = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign meas_valid = valid_q;
  assign period     = period_q;
  assign high_time  = high_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: table-driven waveforms, directed corner sequences and a randomized
// run, all checked every cycle against a timestamp-based reference model.
module tb_period_meter;

  localparam int unsigned CNT_W = 8;
  localparam int MAXC = 255;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sig_in = 1'b0;
  logic             clr = 1'b0;
  logic             meas_ready = 1'b0;
  logic             meas_valid, overrun, timeout;
  logic [CNT_W-1:0] period, high_time;

  period_meter #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .clr       (clr),
    .meas_ready(meas_ready),
    .meas_valid(meas_valid),
    .period    (period),
    .high_time (high_time),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: remembers when the current measurement's rise and fall were detected.
  bit smp[3];
  int m_t, m_trise, m_hi;
  bit m_armed, m_fell;
  int e_period, e_high;
  bit e_valid, e_ovr, e_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    smp = '{0, 0, 0};
    m_t = 0; m_trise = 0; m_hi = 0; m_armed = 0; m_fell = 0;
    e_period = 0; e_high = 0; e_valid = 0; e_ovr = 0; e_to = 0;
  endtask

  task automatic model_step();
    bit rise, fall, pub;
    int el, pp, ph;
    m_t++;
    // sig_in takes two edges to reach the detector, which compares with one edge older.
    rise = smp[1] && !smp[2];
    fall = !smp[1] && smp[2];
    pub = 0; pp = 0; ph = 0;
    if (clr) begin
      m_armed = 0; m_fell = 0; m_hi = 0;
      e_period = 0; e_high = 0; e_valid = 0; e_ovr = 0; e_to = 0;
    end else begin
      el = m_t - m_trise;
      if (m_armed && el == MAXC) begin
        m_armed = 0;
        e_to = 1;
      end else begin
        if (rise) e_to = 0;
        if (m_armed && rise) begin
          if (m_fell) begin
            pub = 1; pp = el; ph = m_hi;
          end
          m_trise = m_t;
          m_fell = 0;
        end else if (m_armed && fall && !m_fell) begin
          m_hi = el;
          m_fell = 1;
        end else if (!m_armed && rise) begin
          m_armed = 1;
          m_fell = 0;
          m_trise = m_t;
        end
      end
      if (pub) begin
        if (!e_valid || meas_ready) begin
          e_period = pp; e_high = ph; e_valid = 1;
        end else begin
          e_ovr = 1;
        end
      end else if (meas_ready) begin
        e_valid = 0;
      end
    end
    smp[2] = smp[1];
    smp[1] = smp[0];
    smp[0] = sig_in;
  endtask

  task automatic check_outputs();
    chk("meas_valid", meas_valid, e_valid);
    chk("period", period, e_period);
    chk("high_time", high_time, e_high);
    chk("overrun", overrun, e_ovr);
    chk("timeout", timeout, e_to);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive_level(input bit v, input int n);
    sig_in = v;
    repeat (n) cycle();
  endtask

  task automatic start_clean();
    sig_in = 0;
    repeat (4) cycle();
    clr = 1;
    cycle();
    clr = 0;
  endtask

  typedef struct {
    int hi;
    int lo;
    int nper;
    bit ready;
    int e_period;
    int e_high;
    bit e_ovr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{hi: 3,  lo: 3,  nper: 3, ready: 1, e_period: 6,  e_high: 3,  e_ovr: 0};
    vecs[1] = '{hi: 10, lo: 30, nper: 2, ready: 0, e_period: 40, e_high: 10, e_ovr: 1};
    vecs[2] = '{hi: 5,  lo: 2,  nper: 4, ready: 1, e_period: 7,  e_high: 5,  e_ovr: 0};
    vecs[3] = '{hi: 1,  lo: 1,  nper: 4, ready: 1, e_period: 2,  e_high: 1,  e_ovr: 0};
    vecs[4] = '{hi: 4,  lo: 4,  nper: 1, ready: 1, e_period: 8,  e_high: 4,  e_ovr: 0};
    vecs[5] = '{hi: 2,  lo: 6,  nper: 1, ready: 0, e_period: 8,  e_high: 2,  e_ovr: 0};

    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", meas_valid, 0);
    chk("rst_period", period, 0);
    chk("rst_timeout", timeout, 0);
    check_outputs();
    reset = 1;

    // Periodic waveforms; the last rise publishes and is checked on the following cycle.
    foreach (vecs[i]) begin
      meas_ready = vecs[i].ready;
      start_clean();
      for (int p = 0; p < vecs[i].nper; p++) begin
        drive_level(1, vecs[i].hi);
        drive_level(0, vecs[i].lo);
      end
      drive_level(1, 3);
      chk($sformatf("vec%0d_valid", i), meas_valid, 1);
      chk($sformatf("vec%0d_period", i), period, vecs[i].e_period);
      chk($sformatf("vec%0d_high", i), high_time, vecs[i].e_high);
      chk($sformatf("vec%0d_overrun", i), overrun, vecs[i].e_ovr);
      if (!vecs[i].ready) begin
        meas_ready = 1;
        cycle();
        meas_ready = 0;
        chk($sformatf("vec%0d_ready_drop", i), meas_valid, 0);
      end
    end

    // Saturation with a held result, then recovery on the next rise.
    meas_ready = 0;
    start_clean();
    drive_level(1, 2);
    drive_level(0, 3);
    drive_level(1, 2);
    drive_level(0, 300);
    chk("sat_timeout", timeout, 1);
    chk("sat_valid_held", meas_valid, 1);
    chk("sat_period_held", period, 5);
    chk("sat_high_held", high_time, 2);
    drive_level(1, 3);
    chk("sat_timeout_clear", timeout, 0);
    chk("sat_no_publish", period, 5);

    // clr in LOW with a pending result.
    start_clean();
    drive_level(1, 2);
    drive_level(0, 3);
    drive_level(1, 2);
    drive_level(0, 3);
    chk("clr_pre_valid", meas_valid, 1);
    clr = 1;
    cycle();
    clr = 0;
    chk("clr_valid", meas_valid, 0);
    chk("clr_period", period, 0);
    chk("clr_high", high_time, 0);
    chk("clr_overrun", overrun, 0);
    chk("clr_timeout", timeout, 0);
    drive_level(1, 3);
    chk("clr_arm_only", meas_valid, 0);
    drive_level(1, 1);
    drive_level(0, 2);
    drive_level(1, 3);
    chk("clr_next_valid", meas_valid, 1);
    chk("clr_next_period", period, 6);

    // Asynchronous reset in the middle of a HIGH phase.
    meas_ready = 1;
    drive_level(1, 2);
    drive_level(0, 2);
    drive_level(1, 3);
    #3;
    reset = 0;
    sig_in = 0;
    model_reset();
    #1;
    chk("arst_valid", meas_valid, 0);
    chk("arst_period", period, 0);
    chk("arst_high", high_time, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_timeout", timeout, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    drive_level(0, 2);
    drive_level(1, 3);
    drive_level(0, 5);
    drive_level(1, 3);
    chk("arst_after_valid", meas_valid, 1);
    chk("arst_after_period", period, 8);
    chk("arst_after_high", high_time, 3);
    chk("arst_after_overrun", overrun, 0);

    // Randomized waveform, handshake and clears against the model.
    for (int i = 0; i < 300; i++) begin
      int len;
      len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(250, 280))
                                        : int'($urandom_range(1, 12));
      sig_in = ~sig_in;
      for (int k = 0; k < len; k++) begin
        meas_ready = ($urandom_range(0, 2) == 0);
        clr = ($urandom_range(0, 149) == 0);
        cycle();
      end
    end
    clr = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
